// File: rtl/blur_window_loader.sv
// Window loader for the blur controller: fetches a 5x4 pixel window byte by byte
// from pixel memory, presents it until the filter finishes, then steps the anchor.
module blur_window_loader #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int ADDR_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    output logic                 mem_read,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_ready,
    output logic [159:0]         window,
    output logic                 window_valid,
    output logic [31:0]          anchor_x,
    output logic [31:0]          anchor_y,
    output logic                 anchor_moving,
    input  logic                 filter_final,
    output logic                 image_done
);

    localparam logic [31:0] W32    = 32'(WIDTH);
    localparam logic [31:0] H32    = 32'(HEIGHT);
    localparam logic [31:0] H_LAST = 32'(HEIGHT - 1);
    localparam logic [4:0]  FC_LAST = 5'd19;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        PRESENT = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [4:0]             fc_q, fc_d;
    logic                   mem_read_q, mem_read_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [159:0]           window_q, window_d;
    logic [31:0]            anchor_x_q, anchor_x_d;
    logic [31:0]            anchor_y_q, anchor_y_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic                   anchor_moving_q, anchor_moving_d;

    // Address of window byte idx; rows below the image replicate the last row.
    function automatic logic [ADDR_BITS-1:0] pix_addr(
        input logic [ADDR_BITS-1:0] base,
        input logic [31:0]          ax,
        input logic [31:0]          ay,
        input logic [4:0]           idx
    );
        logic [31:0] row;
        logic [31:0] col;
        logic [31:0] lin;
        row = ay + {29'd0, idx[4:2]};
        if (row > H_LAST) begin
            row = H_LAST;
        end
        col = ax + {30'd0, idx[1:0]};
        lin = row * W32 + col;
        return base + lin[ADDR_BITS-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            fc_q            <= '0;
            mem_read_q      <= 1'b0;
            mem_addr_q      <= '0;
            window_q        <= '0;
            anchor_x_q      <= '0;
            anchor_y_q      <= '0;
            base_q          <= '0;
            anchor_moving_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            fc_q            <= fc_d;
            mem_read_q      <= mem_read_d;
            mem_addr_q      <= mem_addr_d;
            window_q        <= window_d;
            anchor_x_q      <= anchor_x_d;
            anchor_y_q      <= anchor_y_d;
            base_q          <= base_d;
            anchor_moving_q <= anchor_moving_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        fc_d            = fc_q;
        mem_read_d      = mem_read_q;
        mem_addr_d      = mem_addr_q;
        window_d        = window_q;
        anchor_x_d      = anchor_x_q;
        anchor_y_d      = anchor_y_q;
        base_d          = base_q;
        anchor_moving_d = 1'b0;

        case (state_q)
            IDLE: begin
                anchor_x_d = '0;
                anchor_y_d = '0;
                fc_d       = '0;
                if (start) begin
                    base_d     = base_addr;
                    mem_read_d = 1'b1;
                    mem_addr_d = pix_addr(base_addr, 32'd0, 32'd0, 5'd0);
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (mem_read_q && mem_ready) begin
                    window_d[{fc_q, 3'b000} +: 8] = mem_rdata;
                    if (fc_q == FC_LAST) begin
                        mem_read_d      = 1'b0;
                        anchor_moving_d = 1'b1;
                        state_d         = PRESENT;
                    end else begin
                        fc_d       = fc_q + 5'd1;
                        mem_addr_d = pix_addr(base_q, anchor_x_q, anchor_y_q, fc_q + 5'd1);
                    end
                end
            end
            PRESENT: begin
                if (filter_final) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                // Issue the first read of the next window directly from here so
                // the new fetch starts without a dead cycle.
                if (anchor_x_q + 32'd4 < W32) begin
                    anchor_x_d = anchor_x_q + 32'd4;
                    fc_d       = '0;
                    mem_read_d = 1'b1;
                    mem_addr_d = pix_addr(base_q, anchor_x_q + 32'd4, anchor_y_q, 5'd0);
                    state_d    = FETCH;
                end else if (anchor_y_q + 32'd4 < H32) begin
                    anchor_x_d = '0;
                    anchor_y_d = anchor_y_q + 32'd4;
                    fc_d       = '0;
                    mem_read_d = 1'b1;
                    mem_addr_d = pix_addr(base_q, 32'd0, anchor_y_q + 32'd4, 5'd0);
                    state_d    = FETCH;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                anchor_x_d = '0;
                anchor_y_d = '0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_read      = mem_read_q;
    assign mem_addr      = mem_addr_q;
    assign window        = window_q;
    assign window_valid  = (state_q == PRESENT);
    assign anchor_x      = anchor_x_q;
    assign anchor_y      = anchor_y_q;
    assign anchor_moving = anchor_moving_q;
    assign image_done    = (state_q == DONE);

endmodule
